// File: rtl/s9234_scan.sv
// s9234 benchmark wrapped with seven scan chains, a 7-bit LFSR pattern
// generator and a 7-bit MISR compactor for self-test.

module s9234_scan #(
  parameter logic [6:0] TPG_SEED  = 7'b0000001,
  parameter logic [6:0] MISR_SEED = 7'b0000000
) (
  input  logic       CK,
  input  logic       scan_en,
  input  logic       bist_en,
  input  logic       TPG_reset,
  input  logic       COMP_reset,
  input  logic       SI_chain1, SI_chain2, SI_chain3, SI_chain4,
  input  logic       SI_chain5, SI_chain6, SI_chain7,
  output logic       SO_chain1, SO_chain2, SO_chain3, SO_chain4,
  output logic       SO_chain5, SO_chain6, SO_chain7,
  input  logic       g22, g23, g32, g36, g37, g38, g39, g40, g41, g42,
  input  logic       g44, g45, g46, g47, g89, g94, g98, g102, g107,
  input  logic       g301, g306, g310, g314, g319,
  input  logic       g557, g558, g559, g560, g561, g562, g563, g564,
  input  logic       g567, g639, g702, g705,
  output logic       g1290, g1293, g2584, g3222, g3600,
  output logic       g4098, g4099, g4100, g4101, g4102, g4103, g4104,
  output logic       g4105, g4106, g4107, g4108, g4109, g4110, g4112,
  output logic       g4121, g4307, g4321, g4422, g4809, g5137,
  output logic       g5468, g5469, g5692, g6282, g6284,
  output logic       g6360, g6362, g6364, g6366, g6368, g6370, g6372, g6374,
  output logic       g6728,
  output logic [6:0] tpg_out
);

  localparam int unsigned NQ  = 228;
  localparam int unsigned NPI = 36;
  localparam int unsigned NPO = 39;
  localparam int unsigned TW  = 7;

  logic [NPI-1:0] pi;
  logic [NPO-1:0] po;
  logic [NQ-1:0]  q, d, q_shift;
  logic [TW-1:0]  tpg, misr, si, chain_in, tails, so;

  assign pi = {g23, g44, g22, g41, g37, g40, g47, g36, g46, g38, g32, g702,
               g39, g42, g45, g567, g639, g705, g564, g563, g562, g561, g560,
               g559, g558, g557, g319, g314, g310, g306, g301, g107, g102,
               g98, g94, g89};

  assign {g4098, g4107, g4104, g4110, g4101, g4105, g4112, g4100, g4109,
          g4102, g4099, g1293, g4103, g4106, g4108, g4121, g1290, g6728,
          g6374, g6372, g6370, g6368, g6366, g6364, g6362, g6360, g6284,
          g6282, g5692, g5469, g5468, g5137, g4809, g4422, g4321, g4307,
          g3600, g3222, g2584} = po;

  s9234_comb u_comb (
    .pi (pi),
    .q  (q),
    .po (po),
    .d  (d)
  );

  assign si       = {SI_chain7, SI_chain6, SI_chain5, SI_chain4,
                     SI_chain3, SI_chain2, SI_chain1};
  assign chain_in = bist_en ? tpg : si;
  assign tails    = {q[227], q[195], q[163], q[131], q[98], q[65], q[32]};
  assign so       = bist_en ? misr : tails;
  assign {SO_chain7, SO_chain6, SO_chain5, SO_chain4,
          SO_chain3, SO_chain2, SO_chain1} = so;
  assign tpg_out  = tpg;

  // One long shift, then each chain head is overwritten with its own input.
  always_comb begin
    q_shift      = {q[NQ-2:0], 1'b0};
    q_shift[0]   = chain_in[0];
    q_shift[33]  = chain_in[1];
    q_shift[66]  = chain_in[2];
    q_shift[99]  = chain_in[3];
    q_shift[132] = chain_in[4];
    q_shift[164] = chain_in[5];
    q_shift[196] = chain_in[6];
  end

  always_ff @(posedge CK or posedge TPG_reset) begin
    if (TPG_reset) begin
      tpg <= TPG_SEED;
    end else if (bist_en) begin
      tpg <= {tpg[5:0], tpg[6] ^ tpg[5]};
    end
  end

  always_ff @(posedge CK or posedge TPG_reset) begin
    if (TPG_reset) begin
      q <= '0;
    end else begin
      q <= scan_en ? q_shift : d;
    end
  end

  always_ff @(posedge CK or posedge COMP_reset) begin
    if (COMP_reset) begin
      misr <= MISR_SEED;
    end else if (bist_en) begin
      misr <= {misr[5:0], misr[6] ^ misr[5]} ^ tails;
    end
  end

endmodule

// Combinational core: primary inputs and present state to primary outputs
// and next state. Stand-in with the same port shape as the gate netlist.
module s9234_comb (
  input  logic [35:0]  pi,
  input  logic [227:0] q,
  output logic [38:0]  po,
  output logic [227:0] d
);

  localparam int unsigned NQ  = 228;
  localparam int unsigned NPI = 36;
  localparam int unsigned NPO = 39;

  for (genvar k = 0; k < NQ; k++) begin : g_next
    assign d[k] = q[(k + 1) % NQ] ^ (pi[k % NPI] & q[(k * 7 + 3) % NQ]);
  end

  for (genvar j = 0; j < NPO; j++) begin : g_out
    assign po[j] = (^q[j * 5 +: 6]) ^ (pi[j % NPI] & pi[(j + 5) % NPI]);
  end

endmodule

// File: tb/tb_s9234_scan.sv
// Directed bench for s9234_scan: TPG sequence/period, scan shift, capture,
// MISR compaction and both asynchronous resets.

module tb_s9234_scan;

  logic         CK = 1'b0;
  logic         scan_en, bist_en, TPG_reset, COMP_reset;
  logic [6:0]   si;
  wire  [6:0]   so;
  logic [35:0]  pi;
  wire  [38:0]  po;
  wire  [6:0]   tpg_out;
  logic [227:0] ref_q;
  wire  [227:0] ref_d;
  wire  [38:0]  ref_po;

  int total = 0;
  int bad   = 0;
  int head [7] = '{0, 33, 66, 99, 132, 164, 196};
  int len  [7] = '{33, 33, 33, 33, 32, 32, 32};
  logic [6:0] m_model;

  always #5 CK = ~CK;

  s9234_scan dut (
    .CK(CK), .scan_en(scan_en), .bist_en(bist_en),
    .TPG_reset(TPG_reset), .COMP_reset(COMP_reset),
    .SI_chain1(si[0]), .SI_chain2(si[1]), .SI_chain3(si[2]), .SI_chain4(si[3]),
    .SI_chain5(si[4]), .SI_chain6(si[5]), .SI_chain7(si[6]),
    .SO_chain1(so[0]), .SO_chain2(so[1]), .SO_chain3(so[2]), .SO_chain4(so[3]),
    .SO_chain5(so[4]), .SO_chain6(so[5]), .SO_chain7(so[6]),
    .g22(pi[33]), .g23(pi[35]), .g32(pi[25]), .g36(pi[28]), .g37(pi[31]),
    .g38(pi[26]), .g39(pi[23]), .g40(pi[30]), .g41(pi[32]), .g42(pi[22]),
    .g44(pi[34]), .g45(pi[21]), .g46(pi[27]), .g47(pi[29]), .g89(pi[0]),
    .g94(pi[1]), .g98(pi[2]), .g102(pi[3]), .g107(pi[4]), .g301(pi[5]),
    .g306(pi[6]), .g310(pi[7]), .g314(pi[8]), .g319(pi[9]),
    .g557(pi[10]), .g558(pi[11]), .g559(pi[12]), .g560(pi[13]),
    .g561(pi[14]), .g562(pi[15]), .g563(pi[16]), .g564(pi[17]),
    .g567(pi[20]), .g639(pi[19]), .g702(pi[24]), .g705(pi[18]),
    .g1290(po[22]), .g1293(po[27]), .g2584(po[0]), .g3222(po[1]), .g3600(po[2]),
    .g4098(po[38]), .g4099(po[28]), .g4100(po[31]), .g4101(po[34]),
    .g4102(po[29]), .g4103(po[26]), .g4104(po[36]), .g4105(po[33]),
    .g4106(po[25]), .g4107(po[37]), .g4108(po[24]), .g4109(po[30]),
    .g4110(po[35]), .g4112(po[32]), .g4121(po[23]), .g4307(po[3]),
    .g4321(po[4]), .g4422(po[5]), .g4809(po[6]), .g5137(po[7]),
    .g5468(po[8]), .g5469(po[9]), .g5692(po[10]), .g6282(po[11]),
    .g6284(po[12]), .g6360(po[13]), .g6362(po[14]), .g6364(po[15]),
    .g6366(po[16]), .g6368(po[17]), .g6370(po[18]), .g6372(po[19]),
    .g6374(po[20]), .g6728(po[21]),
    .tpg_out(tpg_out)
  );

  // Reference copy of the combinational core, fed with the state we load.
  s9234_comb u_ref (.pi(pi), .q(ref_q), .po(ref_po), .d(ref_d));

  task automatic clk_edge;
    @(posedge CK);
    @(negedge CK);
  endtask

  // Bit driven on edge e lands at chain offset 33-e after 33 edges.
  task automatic load_state(input logic [227:0] s);
    scan_en = 1'b1;
    bist_en = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      for (int c = 0; c < 7; c++) begin
        si[c] = (33 - e < len[c]) ? s[head[c] + 33 - e] : 1'b0;
      end
      clk_edge();
    end
  endtask

  task automatic test_reset;
    TPG_reset = 1'b1; COMP_reset = 1'b1;
    scan_en = 1'b0; bist_en = 1'b0; si = '0; pi = '0; ref_q = '0;
    #2;
    total++; if (tpg_out !== 7'b0000001) begin bad++; $display("FAIL reset_tpg: got %b want 0000001", tpg_out); end
    total++; if (so !== 7'b0) begin bad++; $display("FAIL reset_chains: got %b want 0000000", so); end
    @(negedge CK);
    bist_en = 1'b1; scan_en = 1'b1; si = 7'b1011101;
    repeat (3) clk_edge();
    total++; if (tpg_out !== 7'b0000001) begin bad++; $display("FAIL reset_hold_tpg: got %b want 0000001", tpg_out); end
    total++; if (so !== 7'b0) begin bad++; $display("FAIL reset_hold_misr: got %b want 0000000", so); end
    bist_en = 1'b0; #1;
    total++; if (so !== 7'b0) begin bad++; $display("FAIL reset_hold_chains: got %b want 0000000", so); end
    COMP_reset = 1'b0;
  endtask

  task automatic test_tpg_sequence;
    logic [6:0] exp_seq [7] = '{7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000,
                                7'b0100000, 7'b1000001, 7'b0000011};
    bist_en = 1'b1; scan_en = 1'b1; TPG_reset = 1'b1;
    #1;
    total++; if (tpg_out !== 7'b0000001) begin bad++; $display("FAIL tpg_seed: got %b want 0000001", tpg_out); end
    @(negedge CK);
    TPG_reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      clk_edge();
      total++;
      if (tpg_out !== exp_seq[i]) begin bad++; $display("FAIL tpg_seq[%0d]: got %b want %b", i, tpg_out, exp_seq[i]); end
    end
  endtask

  task automatic test_tpg_period;
    bist_en = 1'b1; scan_en = 1'b0;
    TPG_reset = 1'b1; #1; TPG_reset = 1'b0;
    for (int i = 1; i <= 381; i++) begin
      clk_edge();
      total++;
      if (tpg_out === 7'b0) begin bad++; $display("FAIL tpg_nonzero at %0d: got %b", i, tpg_out); end
      total++;
      if ((tpg_out === 7'b0000001) !== (i % 127 == 0)) begin
        bad++; $display("FAIL tpg_period at %0d: got %b seed_expected=%0d", i, tpg_out, (i % 127 == 0));
      end
    end
  endtask

  task automatic test_scan_shift;
    logic [39:0] pat1 = 40'hA5_3C96_E7CD;
    logic [39:0] pat5 = 40'h5A_C3E1_7B24;
    bist_en = 1'b0; scan_en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      si    = 7'($urandom);
      si[0] = pat1[n-1];
      si[4] = pat5[n-1];
      clk_edge();
      if (n >= 33) begin
        total++;
        if (so[0] !== pat1[n-33]) begin bad++; $display("FAIL shift_chain1 n=%0d: got %b want %b", n, so[0], pat1[n-33]); end
      end
      if (n >= 32) begin
        total++;
        if (so[4] !== pat5[n-32]) begin bad++; $display("FAIL shift_chain5 n=%0d: got %b want %b", n, so[4], pat5[n-32]); end
      end
    end
  endtask

  task automatic test_capture;
    logic [255:0] w;
    logic [63:0]  p;
    logic [227:0] s, exp_d, got;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
      p = {$urandom, $urandom};
      s = w[227:0];
      load_state(s);
      pi = p[35:0];
      ref_q = s;
      #1;
      total++;
      if (po !== ref_po) begin bad++; $display("FAIL capture_po t=%0d: got %h want %h", t, po, ref_po); end
      exp_d = ref_d;
      scan_en = 1'b0;
      clk_edge();
      scan_en = 1'b1;
      got = '0;
      for (int e = 0; e < 33; e++) begin
        for (int c = 0; c < 7; c++) begin
          if (e < len[c]) got[head[c] + len[c] - 1 - e] = so[c];
        end
        clk_edge();
      end
      total++;
      if (got !== exp_d) begin bad++; $display("FAIL capture_d t=%0d: got %h want %h", t, got, exp_d); end
    end
  endtask

  task automatic test_misr;
    logic [255:0] w = {8{32'hC3A5_1E97}};
    logic [227:0] s;
    logic [6:0]   tl;
    s = w[227:0];
    TPG_reset = 1'b1; #1; TPG_reset = 1'b0;
    load_state(s);
    COMP_reset = 1'b1; bist_en = 1'b1;
    #1;
    total++; if (so !== 7'b0) begin bad++; $display("FAIL misr_reset: got %b want 0000000", so); end
    COMP_reset = 1'b0;
    m_model = 7'b0;
    for (int e = 1; e <= 10; e++) begin
      for (int c = 0; c < 7; c++) tl[c] = s[head[c] + len[c] - e];
      m_model = {m_model[5:0], m_model[6] ^ m_model[5]} ^ tl;
      clk_edge();
      total++;
      if (so !== m_model) begin bad++; $display("FAIL misr_step e=%0d: got %b want %b", e, so, m_model); end
    end
    total++; if (tpg_out !== 7'b0011000) begin bad++; $display("FAIL misr_tpg: got %b want 0011000", tpg_out); end
    bist_en = 1'b0; si = '0;
    repeat (3) clk_edge();
    bist_en = 1'b1; #1;
    total++; if (so !== m_model) begin bad++; $display("FAIL misr_hold: got %b want %b", so, m_model); end
    total++; if (tpg_out !== 7'b0011000) begin bad++; $display("FAIL tpg_hold: got %b want 0011000", tpg_out); end
  endtask

  // Called while CK is low, right after test_misr.
  task automatic test_async_reset;
    logic [6:0] acc;
    TPG_reset = 1'b1; #1;
    total++; if (tpg_out !== 7'b0000001) begin bad++; $display("FAIL async_tpg: got %b want 0000001", tpg_out); end
    total++; if (so !== m_model) begin bad++; $display("FAIL async_misr_kept: got %b want %b", so, m_model); end
    bist_en = 1'b0; #1;
    total++; if (so !== 7'b0) begin bad++; $display("FAIL async_chains: got %b want 0000000", so); end
    TPG_reset = 1'b0; scan_en = 1'b1; si = '0;
    acc = so;
    for (int e = 0; e < 32; e++) begin
      clk_edge();
      acc = acc | so;
    end
    total++; if (acc !== 7'b0) begin bad++; $display("FAIL async_clear_all: got %b want 0000000", acc); end
  endtask

  task automatic test_comp_independent;
    logic [255:0] w = {8{32'h6D2B_F04A}};
    logic [227:0] s;
    logic [6:0]   t2;
    s = w[227:0];
    load_state(s);
    for (int c = 0; c < 7; c++) t2[c] = s[head[c] + len[c] - 1];
    COMP_reset = 1'b1; #1;
    total++; if (so !== t2) begin bad++; $display("FAIL comp_keeps_chains: got %b want %b", so, t2); end
    total++; if (tpg_out !== 7'b0000001) begin bad++; $display("FAIL comp_keeps_tpg: got %b want 0000001", tpg_out); end
    bist_en = 1'b1; #1;
    total++; if (so !== 7'b0) begin bad++; $display("FAIL comp_clears_misr: got %b want 0000000", so); end
    COMP_reset = 1'b0; bist_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tpg_sequence();
    test_tpg_period();
    test_scan_shift();
    test_capture();
    test_misr();
    test_async_reset();
    test_comp_independent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
